// File: rtl/spi_pkg.sv
// Shared definitions for the 12-bit SPI link.
// Word width, counter width and slave state encoding.
package spi_pkg;

    localparam int SPI_DW    = 12;
    localparam int SPI_CNT_W = $clog2(SPI_DW + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        HOLD
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection.
// Edges compare the last stage against a delayed copy.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchronizer chain plus one delayed copy of its output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampling SPI slave: receives one MSB-first word per
// chip-select frame and shifts a response word out on miso.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DW          = SPI_DW,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic          miso,
    input  logic [DW-1:0] tx_data,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          frame_err,
    output logic          busy
);

    localparam int CW = $clog2(DW + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_state_t    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rx_sh;
    logic [DW-1:0] tx_sh;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b0)
    ) u_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .level(sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b1)
    ) u_cs (
        .clk  (clk),
        .rst  (rst),
        .din  (cs),
        .level(cs_lvl),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b0)
    ) u_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (mosi),
        .level(mosi_lvl),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    // Frame FSM with registered outputs and shift registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WAIT_IDLE;
            cnt       <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            miso      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                // The cs synchronizer resets high, so its level is only
                // trusted once it has stayed high past the reset flush.
                WAIT_IDLE: begin
                    miso <= 1'b0;
                    busy <= 1'b0;
                    if (!cs_lvl) begin
                        cnt <= '0;
                    end else if (cnt == CW'(SYNC_STAGES)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        tx_sh <= tx_data;
                        miso  <= tx_data[DW-1];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (sclk_fall) begin
                        rx_sh <= {rx_sh[DW-2:0], mosi_lvl};
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(DW - 1)) begin
                            rx_data  <= {rx_sh[DW-2:0], mosi_lvl};
                            rx_valid <= 1'b1;
                            miso     <= 1'b0;
                            state    <= HOLD;
                        end
                    end else if (sclk_rise) begin
                        tx_sh <= {tx_sh[DW-2:0], 1'b0};
                        miso  <= tx_sh[DW-2];
                    end
                end
                HOLD: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    miso  <= 1'b0;
                    busy  <= 1'b0;
                    state <= WAIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx.
// Bit-banged SPI master with hand-computed expectations.
module tb_spi_slave_rx;

    localparam int DW      = 12;
    localparam int PH      = 10;
    localparam int MIN_GAP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs;
    logic          mosi;
    logic          miso;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    int            n_chk  = 0;
    int            n_pass = 0;
    int            n_valid = 0;
    int            n_ferr  = 0;
    logic [DW-1:0] rx_log[$];
    logic          seen[DW];
    int            v0;
    int            f0;
    logic [DW-1:0] exp_tx;

    spi_slave_rx u_dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters and received-word log.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            rx_log.push_back(rx_data);
        end
        if (frame_err) n_ferr++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // bits[15] is launched with cs; nfall falling sclk edges follow.
    task automatic xfer(input logic [15:0] bits, input int nfall,
                        input bit abort, input int rst_at,
                        input int gap);
        cs   = 1'b0;
        mosi = bits[15];
        for (int i = 0; i < nfall; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("rst_miso", miso, 0);
                check("rst_busy", busy, 0);
                check("rst_rxd", rx_data, 0);
                rst = 1'b1;
            end
            repeat (PH) @(negedge clk);
            if (i == 2 && rst_at < 0) check("busy_mid", busy, 1);
            if (i < DW) seen[i] = miso;
            sclk = 1'b0;
            repeat (PH) @(negedge clk);
            if (abort && i == nfall - 1) break;
            sclk = 1'b1;
            mosi = (i + 1 < 16) ? bits[14-i] : 1'b0;
        end
        repeat (PH) @(negedge clk);
        cs = 1'b1;
        if (abort) begin
            repeat (PH) @(negedge clk);
            sclk = 1'b1;
        end
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        cs      = 1'b1;
        sclk    = 1'b1;
        mosi    = 1'b0;
        tx_data = '0;
        repeat (5) @(negedge clk);
        check("reset_miso", miso, 0);
        check("reset_rxd", rx_data, 0);
        check("reset_valid", rx_valid, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Plain frame 12'hAAA.
        v0 = n_valid; f0 = n_ferr;
        xfer({12'hAAA, 4'h0}, DW, 1'b0, -1, 20);
        check("aaa_nvalid", n_valid - v0, 1);
        check("aaa_rxd", rx_data, 12'hAAA);
        check("aaa_ferr", n_ferr - f0, 0);
        check("aaa_busy_end", busy, 0);

        // Response word captured at frame start, then tx_data changes.
        exp_tx  = 12'hC35;
        tx_data = exp_tx;
        v0 = n_valid;
        fork
            xfer({12'h5A3, 4'h0}, DW, 1'b0, -1, 20);
            begin
                repeat (30) @(negedge clk);
                tx_data = 12'h000;
            end
        join
        for (int i = 0; i < DW; i++)
            check($sformatf("miso_bit%0d", i), seen[i], exp_tx[DW-1-i]);
        check("5a3_nvalid", n_valid - v0, 1);
        check("5a3_rxd", rx_data, 12'h5A3);
        check("idle_miso", miso, 0);

        // cs raised after 5 bits.
        tx_data = 12'hFFF;
        v0 = n_valid; f0 = n_ferr;
        xfer({12'h3C3, 4'h0}, 5, 1'b1, -1, 20);
        check("abort_ferr", n_ferr - f0, 1);
        check("abort_nvalid", n_valid - v0, 0);
        check("abort_rxd", rx_data, 12'h5A3);
        check("abort_miso", miso, 0);
        check("abort_busy", busy, 0);

        // 15 sclk pulses: 12'h0F0 then three extra ones.
        tx_data = 12'h000;
        v0 = n_valid; f0 = n_ferr;
        xfer({12'h0F0, 3'b111, 1'b0}, 15, 1'b0, -1, 20);
        check("x15_nvalid", n_valid - v0, 1);
        check("x15_rxd", rx_data, 12'h0F0);
        check("x15_ferr", n_ferr - f0, 0);

        // Reset after 6 bits, released with cs low.
        tx_data = 12'hFFF;
        v0 = n_valid; f0 = n_ferr;
        xfer({12'hABC, 4'h0}, DW, 1'b0, 6, 20);
        check("rstf_nvalid", n_valid - v0, 0);
        check("rstf_ferr", n_ferr - f0, 0);
        check("rstf_rxd", rx_data, 0);
        check("rstf_miso", miso, 0);
        check("rstf_busy", busy, 0);
        v0 = n_valid;
        xfer({12'h123, 4'h0}, DW, 1'b0, -1, 20);
        check("post_rst_nvalid", n_valid - v0, 1);
        check("post_rst_rxd", rx_data, 12'h123);

        // Back-to-back frames with minimum cs-high gap.
        rx_log.delete();
        v0 = n_valid;
        xfer({12'hFFF, 4'h0}, DW, 1'b0, -1, MIN_GAP);
        xfer({12'h001, 4'h0}, DW, 1'b0, -1, 20);
        check("b2b_nvalid", n_valid - v0, 2);
        if (rx_log.size() == 2) begin
            check("b2b_first", rx_log[0], 12'hFFF);
            check("b2b_second", rx_log[1], 12'h001);
        end else begin
            check("b2b_log_size", rx_log.size(), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Clock-domain SPI slave forming the far end of the team's 12-bit SPI link. It oversamples `sclk`, `cs` and `mosi` with the system clock and shifts in one MSB-first word per chip-select frame. It presents each completed word with a one-cycle valid pulse and simultaneously shifts a response word out on `miso`. It sits on the peripheral side of the link, opposite the existing SPI master.

## Interface
- `DW`, 12: word width in bits; also the frame length.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers (≥2).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `sclk`  input  1  serial clock from master; asynchronous to `clk`.
- `cs`  input  1  chip select from master; active low.
- `mosi`  input  1  serial data from master.
- `miso`  output  1  serial data to master.
- `tx_data`  input  DW  response word, captured at frame start.
- `rx_data`  output  DW  last completed received word.
- `rx_valid`  output  1  one-cycle pulse: `rx_data` updated.
- `frame_err`  output  1  one-cycle pulse: `cs` rose before DW bits were received.
- `busy`  output  1  high while in SHIFT or HOLD.

## Operation
- Protocol:
  - The master launches each `mosi` bit on a `sclk` rising edge and asserts `cs` low together with bit DW-1.
  - The slave samples `mosi` on the synchronized `sclk` falling edge, MSB first.
  - The slave drives `miso` on synchronized `sclk` rising edges.
- Reset values: `miso`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, bit counter 0, state WAIT_IDLE.
- States:
  - WAIT_IDLE: wait for synchronized `cs`=1, then go to IDLE. This prevents joining a frame mid-way after reset.
  - IDLE: on detected `cs` falling edge, capture `tx_data` into the tx shift register, drive `miso`=`tx_data[DW-1]`, clear the counter, go to SHIFT.
  - SHIFT, on each `sclk` falling edge: shift the synchronized `mosi` into the rx shifter and increment the counter. When the counter reaches DW:
    - load `rx_data`;
    - pulse `rx_valid`;
    - go to HOLD.
  - SHIFT, on each `sclk` rising edge (except the one coincident with the `cs` fall): shift tx and drive the next `miso` bit.
  - HOLD: ignore further `sclk` edges and hold `miso` at 0; on `cs` rising, go to IDLE.
- `cs` rising in SHIFT: pulse `frame_err`, discard partial data (`rx_data` unchanged), drive `miso`=0, go to IDLE.
- A `cs` edge and a `sclk` edge detected in the same cycle: the `cs` edge wins and the `sclk` edge is ignored.
- `miso` is 0 in every state except SHIFT.
- The counter is a plain binary count from 0 to DW. It never wraps, because HOLD absorbs any excess clocks.

## Timing
- Edge detect: a pin transition is recognised SYNC_STAGES+1 `clk` cycles after it occurs (3 at default). Detection compares the last synchronizer stage with a delayed copy.
- `sclk` high and low phases must each be ≥ SYNC_STAGES+2 `clk` cycles. Faster `sclk` is unsupported; behaviour is undefined.
- `rx_valid` and `rx_data` update in the cycle after the DW-th falling edge is detected. `rx_data` then holds until the next valid frame.
- `miso` updates 1 `clk` after detection of the corresponding `sclk` rising or `cs` falling edge.
- `frame_err` asserts 1 `clk` after the early `cs` rise is detected.
- `busy` asserts 1 `clk` after the `cs` falling edge is detected and deasserts 1 `clk` after the `cs` rising edge is detected.
- Back-to-back frames: `cs` must stay high for ≥ SYNC_STAGES+2 `clk` cycles between frames.
- Asynchronous reset in mid-frame clears everything immediately. After release the block stays in WAIT_IDLE until `cs` is seen high.

## Structure
- Package `spi_pkg`:
  - `SPI_DW` = 12.
  - State enum {WAIT_IDLE, IDLE, SHIFT, HOLD}.
  - Counter width `$clog2(SPI_DW+1)`.
- Sub-module `spi_sync_edge`: SYNC_STAGES synchronizer plus rise/fall detect, async active-low reset. The reset value is a parameter: 1 for `cs`, 0 for the others.
  - Instantiated for `sclk`, `cs` and `mosi`; the `mosi` instance uses only the level output.

## Test plan
- Frame `mosi`=12'hAAA with `sclk` at 10 `clk` per phase → single `rx_valid` pulse, `rx_data`=12'hAAA, `frame_err`=0.
- `tx_data`=12'hC35 at frame start while receiving 12'h5A3 → `miso` sequence 1,1,0,0,0,0,1,1,0,1,0,1 on the rising edges; `rx_data`=12'h5A3.
- `cs` raised after 5 bits → `frame_err` pulse, no `rx_valid`, `rx_data` keeps its previous value, `miso`=0.
- 15 `sclk` pulses in one frame of 12'h0F0 followed by 3 extra 1s → `rx_data`=12'h0F0 with exactly one `rx_valid`; extra bits ignored.
- `rst` asserted after 6 bits, released with `cs` still low, remaining pulses continue → all outputs 0, no `rx_valid`. The next full frame 12'h123 is received correctly.
- Two back-to-back frames 12'hFFF then 12'h001 with minimum `cs`-high gap → two `rx_valid` pulses with the correct values in order.
